// File: rtl/stereo_pkg.sv
// Shared types and constants for the stereo depth pipeline control path.
package stereo_pkg;

   localparam int SEQ_FRAME_WORDS = 12800;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_ARM     = 3'd1,
      SEQ_CAPTURE = 3'd2,
      SEQ_START   = 3'd3,
      SEQ_MATCH   = 3'd4,
      SEQ_HOLD    = 3'd5
   } seq_state_t;

endpackage

// File: rtl/capture_gate.sv
// Per-camera write gate: admits exactly one address-aligned frame into its buffer
// between clears.
module capture_gate
   import stereo_pkg::*;
#(
   parameter int FRAME_WORDS = SEQ_FRAME_WORDS,
   parameter int ADDR_W      = 17
) (
   input  logic              clk_in,
   input  logic              rst_in_n,
   input  logic              clear_in,
   input  logic              kill_in,
   input  logic              active_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              wea_in,
   output logic              wea_out,
   output logic              start_out,
   output logic              done_out,
   output logic              done_next_out
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

   logic cap_q, cap_d;
   logic done_q, done_d;
   logic last_write;

   assign start_out     = active_in & ~cap_q & ~done_q & wea_in & (addr_in == '0);
   assign wea_out       = wea_in & ~kill_in & ((cap_q & ~done_q) | start_out);
   assign last_write    = wea_out & (addr_in == LAST_ADDR);
   // Look-ahead done lets the sequencer leave CAPTURE the cycle after the last write.
   assign done_next_out = done_q | last_write;
   assign done_out      = done_q;

   always_comb begin
      cap_d  = cap_q;
      done_d = done_q;
      if (start_out) begin
         cap_d = 1'b1;
      end
      if (last_write) begin
         cap_d  = 1'b0;
         done_d = 1'b1;
      end
      if (clear_in) begin
         cap_d  = 1'b0;
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         cap_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cap_q  <= cap_d;
         done_q <= done_d;
      end
   end

endmodule

// File: rtl/stereo_frame_sequencer.sv
// One-frame-at-a-time stereo capture/match sequencer.
// Optional phase watchdog enabled by defining SEQ_TIMEOUT_EN.
module stereo_frame_sequencer
   import stereo_pkg::*;
#(
   parameter int FRAME_WORDS    = SEQ_FRAME_WORDS,
   parameter int ADDR_W         = 17,
   parameter int HOLD_W         = 24,
   parameter int TIMEOUT_CYCLES = 2**24
) (
   input  logic              clk_in,
   input  logic              rst_in_n,
   input  logic              pacing_in,
   input  logic [HOLD_W-1:0] hold_in,
   input  logic [ADDR_W-1:0] l_addr_in,
   input  logic              l_wea_in,
   input  logic [ADDR_W-1:0] r_addr_in,
   input  logic              r_wea_in,
   output logic              l_wea_out,
   output logic              r_wea_out,
   output logic              match_start_out,
   input  logic              match_done_in,
   output logic              busy_out,
   output logic [2:0]        state_out,
   output logic [15:0]       frame_count_out,
   output logic              timeout_out
);

   seq_state_t        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              match_start_q, busy_q;
   logic              active, enter_arm, gate_clear, wd_fire;
   logic              l_start, r_start, l_done, r_done, l_done_next, r_done_next;

   assign active     = (state_q == SEQ_ARM) || (state_q == SEQ_CAPTURE);
   assign enter_arm  = (state_d == SEQ_ARM) && (state_q != SEQ_ARM);
   assign gate_clear = enter_arm | wd_fire;

   capture_gate #(.FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)) u_left (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .clear_in(gate_clear), .kill_in(wd_fire),
      .active_in(active), .addr_in(l_addr_in), .wea_in(l_wea_in), .wea_out(l_wea_out),
      .start_out(l_start), .done_out(l_done), .done_next_out(l_done_next)
   );

   capture_gate #(.FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)) u_right (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .clear_in(gate_clear), .kill_in(wd_fire),
      .active_in(active), .addr_in(r_addr_in), .wea_in(r_wea_in), .wea_out(r_wea_out),
      .start_out(r_start), .done_out(r_done), .done_next_out(r_done_next)
   );

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         SEQ_IDLE:    if (pacing_in) state_d = SEQ_ARM;
         SEQ_ARM:     if (l_start | r_start) state_d = SEQ_CAPTURE;
         SEQ_CAPTURE: if (l_done_next & r_done_next) state_d = SEQ_START;
         SEQ_START:   state_d = SEQ_MATCH;
         SEQ_MATCH: begin
            if (match_done_in) begin
               state_d     = SEQ_HOLD;
               hold_cnt_d  = hold_in;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
         end
         SEQ_HOLD: begin
            if (hold_cnt_q == '0) state_d = pacing_in ? SEQ_ARM : SEQ_IDLE;
            else                  hold_cnt_d = hold_cnt_q - 1'b1;
         end
         default: state_d = SEQ_IDLE;
      endcase
      // Watchdog abort overrides whatever the phase was about to do.
      if (wd_fire) begin
         state_d     = SEQ_IDLE;
         hold_cnt_d  = hold_cnt_q;
         frame_cnt_d = frame_cnt_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q       <= SEQ_IDLE;
         hold_cnt_q    <= '0;
         frame_cnt_q   <= '0;
         match_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         match_start_q <= (state_d == SEQ_START);
         busy_q        <= (state_d != SEQ_IDLE);
      end
   end

`ifdef SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_q, timeout_d;
   logic            wd_counting;

   assign wd_counting = (state_q == SEQ_ARM) || (state_q == SEQ_CAPTURE) || (state_q == SEQ_MATCH);
   // Fires on the last allowed cycle so a phase lasts exactly TIMEOUT_CYCLES cycles.
   assign wd_fire     = wd_counting && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q;
      if (enter_arm || ((state_d == SEQ_MATCH) && (state_q != SEQ_MATCH))) wd_cnt_d = '0;
      else if (wd_counting)                                                  wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_fire)                                                   timeout_d = 1'b1;
      else if ((state_q == SEQ_IDLE) && (state_d == SEQ_ARM))        timeout_d = 1'b0;
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_out = timeout_q;
`else
   assign wd_fire     = 1'b0;
   assign timeout_out = 1'b0;
`endif

   assign match_start_out = match_start_q;
   assign busy_out        = busy_q;
   assign state_out       = state_q;
   assign frame_count_out = frame_cnt_q;

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// Directed bench for stereo_frame_sequencer: a cycle table for one full frame plus
// hand-written sequences for pacing, hold-off, misaligned arm, watchdog and reset.
module tb_stereo_frame_sequencer;

   localparam int FW = 16;
   localparam int AW = 17;
   localparam int HW = 24;
   localparam int TO = 200;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_CAP = 3'd2,
                          ST_START = 3'd3, ST_MATCH = 3'd4, ST_HOLD = 3'd5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pacing = 1'b0;
   logic [HW-1:0] hold = '0;
   logic [AW-1:0] l_addr = '0, r_addr = '0;
   logic          l_wea = 1'b0, r_wea = 1'b0, match_done = 1'b0;
   logic          l_wea_o, r_wea_o, mstart, busy, tmo;
   logic [2:0]    st;
   logic [15:0]   fcnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stereo_frame_sequencer #(
      .FRAME_WORDS(FW), .ADDR_W(AW), .HOLD_W(HW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_in(clk), .rst_in_n(rst_n), .pacing_in(pacing), .hold_in(hold),
      .l_addr_in(l_addr), .l_wea_in(l_wea), .r_addr_in(r_addr), .r_wea_in(r_wea),
      .l_wea_out(l_wea_o), .r_wea_out(r_wea_o), .match_start_out(mstart),
      .match_done_in(match_done), .busy_out(busy), .state_out(st),
      .frame_count_out(fcnt), .timeout_out(tmo)
   );

   typedef struct {
      logic        pacing;
      logic [4:0]  la, ra;
      logic        lw, rw, md;
      logic        exp_lw, exp_rw, exp_ms;
      logic [2:0]  exp_st;
      logic [15:0] exp_fc;
   } vec_t;

   vec_t tbl[32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int n;
      n = 0;
      while (st !== s && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, st, s);
   endtask

   task automatic pulse_done();
      @(posedge clk); #1; match_done = 1'b1;
      @(posedge clk); #1; match_done = 1'b0;
   endtask

   // Both cameras write every cycle from their offsets; counts gated writes and
   // records the first cycle START is seen.
   task automatic run_frame(input int loff, input int roff, input int n, input int drop_at,
                            output int lw_cnt, output int rw_cnt, output int start_idx,
                            output int r_first);
      lw_cnt = 0; rw_cnt = 0; start_idx = -1; r_first = -1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == drop_at) pacing = 1'b0;
         l_addr = AW'((loff + i) % FW);
         r_addr = AW'((roff + i) % FW);
         l_wea = 1'b1; r_wea = 1'b1;
         #4;
         if (l_wea_o === 1'b1) lw_cnt++;
         if (r_wea_o === 1'b1) begin
            rw_cnt++;
            if (r_first < 0) r_first = i;
         end
         if (st === ST_START && start_idx < 0) start_idx = i;
      end
      l_wea = 1'b0; r_wea = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int lw, rw, sidx, rfirst, hc, mc;

      for (int i = 0; i < 32; i++)
         tbl[i] = '{pacing: 1'b1, la: 5'd0, ra: 5'd0, lw: 1'b0, rw: 1'b0, md: 1'b0,
                    exp_lw: 1'b0, exp_rw: 1'b0, exp_ms: 1'b0, exp_st: ST_MATCH, exp_fc: 16'd0};
      tbl[0].exp_st = ST_IDLE;
      tbl[1].lw = 1'b1; tbl[1].rw = 1'b1; tbl[1].exp_lw = 1'b1; tbl[1].exp_rw = 1'b1;
      tbl[1].exp_st = ST_ARM;
      for (int i = 2; i <= 16; i++) begin
         tbl[i].la = 5'(i - 1); tbl[i].ra = 5'(i - 1);
         tbl[i].lw = 1'b1; tbl[i].rw = 1'b1;
         tbl[i].exp_lw = 1'b1; tbl[i].exp_rw = 1'b1; tbl[i].exp_st = ST_CAP;
      end
      tbl[17].exp_st = ST_START; tbl[17].exp_ms = 1'b1;
      tbl[28].md = 1'b1;
      tbl[29].exp_st = ST_HOLD; tbl[29].exp_fc = 16'd1;
      tbl[30].exp_st = ST_ARM;  tbl[30].exp_fc = 16'd1;
      tbl[31].exp_st = ST_ARM;  tbl[31].exp_fc = 16'd1;
      tbl[31].la = 5'd5; tbl[31].lw = 1'b1; tbl[31].ra = 5'd3; tbl[31].rw = 1'b1;

      // Reset state, with write strobes active to show they are gated.
      l_wea = 1'b1; r_wea = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", st, ST_IDLE);
      chk("rst_busy", busy, 0);
      chk("rst_mstart", mstart, 0);
      chk("rst_fcnt", fcnt, 0);
      chk("rst_timeout", tmo, 0);
      chk("rst_lwea", l_wea_o, 0);
      chk("rst_rwea", r_wea_o, 0);
      l_wea = 1'b0; r_wea = 1'b0;
      rst_n = 1'b1;

      // Single aligned frame, hold 0, pacing held high.
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         pacing = tbl[i].pacing;
         l_addr = AW'(tbl[i].la); r_addr = AW'(tbl[i].ra);
         l_wea = tbl[i].lw; r_wea = tbl[i].rw; match_done = tbl[i].md;
         #4;
         chk($sformatf("v%0d_lwea", i), l_wea_o, tbl[i].exp_lw);
         chk($sformatf("v%0d_rwea", i), r_wea_o, tbl[i].exp_rw);
         chk($sformatf("v%0d_mstart", i), mstart, tbl[i].exp_ms);
         chk($sformatf("v%0d_state", i), st, tbl[i].exp_st);
         chk($sformatf("v%0d_busy", i), busy, (tbl[i].exp_st != ST_IDLE));
         chk($sformatf("v%0d_fcnt", i), fcnt, tbl[i].exp_fc);
         chk($sformatf("v%0d_timeout", i), tmo, 0);
      end
      l_wea = 1'b0; r_wea = 1'b0; match_done = 1'b0;

      // Pacing dropped mid-capture: frame completes, then IDLE and no more writes.
      run_frame(0, 0, 17, 4, lw, rw, sidx, rfirst);
      chk("drop_lwrites", lw, 16);
      chk("drop_rwrites", rw, 16);
      chk("drop_start_idx", sidx, 16);
      wait_state(ST_MATCH, 5, "drop_reach_match");
      pulse_done();
      chk("drop_hold", st, ST_HOLD);
      chk("drop_fcnt", fcnt, 2);
      @(posedge clk); #1;
      chk("drop_idle", st, ST_IDLE);
      chk("drop_busy", busy, 0);
      run_frame(0, 0, 20, -1, lw, rw, sidx, rfirst);
      chk("drop_no_lwrites", lw, 0);
      chk("drop_no_rwrites", rw, 0);
      chk("drop_still_idle", st, ST_IDLE);

      // Hold-off of 5 gives 6 HOLD cycles.
      hold = HW'(5);
      pacing = 1'b1;
      wait_state(ST_ARM, 5, "hold_reach_arm");
      run_frame(0, 0, 18, -1, lw, rw, sidx, rfirst);
      chk("hold_start_idx", sidx, 16);
      wait_state(ST_MATCH, 5, "hold_reach_match");
      pulse_done();
      hc = 0;
      while (st === ST_HOLD && hc < 50) begin
         hc++;
         @(posedge clk); #1;
      end
      chk("hold_cycles", hc, 6);
      chk("hold_exit_arm", st, ST_ARM);
      chk("hold_fcnt", fcnt, 3);

      // Right camera mid-frame at arm: waits for its address to wrap to 0.
      run_frame(0, 7, 27, -1, lw, rw, sidx, rfirst);
      chk("mid_lwrites", lw, 16);
      chk("mid_rwrites", rw, 16);
      chk("mid_r_first", rfirst, 9);
      chk("mid_start_idx", sidx, 25);
      wait_state(ST_MATCH, 5, "mid_reach_match");
      pulse_done();
      chk("mid_fcnt", fcnt, 4);
      wait_state(ST_ARM, 20, "mid_rearm");

      // Watchdog: never complete the match.
      run_frame(0, 0, 17, -1, lw, rw, sidx, rfirst);
      chk("wd_start_idx", sidx, 16);
      wait_state(ST_MATCH, 5, "wd_reach_match");
      mc = 0;
      while (st === ST_MATCH && mc < 300) begin
         mc++;
         @(posedge clk); #1;
      end
`ifdef SEQ_TIMEOUT_EN
      chk("wd_match_cycles", mc, TO);
      chk("wd_idle", st, ST_IDLE);
      chk("wd_flag", tmo, 1);
      chk("wd_busy", busy, 0);
      chk("wd_fcnt_unchanged", fcnt, 4);
      @(posedge clk); #1;
      chk("wd_rearm", st, ST_ARM);
      chk("wd_flag_cleared", tmo, 0);
`else
      chk("nowd_match_cycles", mc, 300);
      chk("nowd_state", st, ST_MATCH);
      chk("nowd_flag", tmo, 0);
      pulse_done();
      chk("nowd_fcnt", fcnt, 5);
      wait_state(ST_ARM, 20, "nowd_rearm");
`endif

      // Asynchronous reset in the middle of CAPTURE.
      @(posedge clk); #1;
      l_addr = '0; r_addr = '0; l_wea = 1'b1; r_wea = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         l_addr = l_addr + 1'b1; r_addr = r_addr + 1'b1;
      end
      #2;
      chk("arst_pre_state", st, ST_CAP);
      chk("arst_pre_lwea", l_wea_o, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_state", st, ST_IDLE);
      chk("arst_busy", busy, 0);
      chk("arst_mstart", mstart, 0);
      chk("arst_fcnt", fcnt, 0);
      chk("arst_timeout", tmo, 0);
      chk("arst_lwea", l_wea_o, 0);
      chk("arst_rwea", r_wea_o, 0);
      l_wea = 1'b0; r_wea = 1'b0;
      repeat (2) @(posedge clk);
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
